// File: rtl/cpu_decode_stage.sv
// Instruction-decode pipeline stage: field extraction, operand read with
// forwarding, busy-bit scoreboard for RAW hazards, valid/full handshake.
module cpu_decode_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned FWD_N  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [31:0]               input_address,
  input  logic [31:0]               input_instruction,
  input  logic                      input_valid,
  output logic                      input_full,
  output logic [ADDR_W-1:0]         reg_s,
  output logic [ADDR_W-1:0]         reg_t,
  input  logic [DATA_W-1:0]         reg_s_data,
  input  logic [DATA_W-1:0]         reg_t_data,
  input  logic [FWD_N-1:0]          fwd_valid,
  input  logic [FWD_N*ADDR_W-1:0]   fwd_reg,
  input  logic [FWD_N*DATA_W-1:0]   fwd_data,
  input  logic                      wb_valid,
  input  logic [ADDR_W-1:0]         wb_reg,
  output logic [31:0]               output_address,
  output logic [31:0]               output_instruction,
  output logic [DATA_W-1:0]         output_operand1,
  output logic [DATA_W-1:0]         output_operand2,
  output logic [ADDR_W-1:0]         output_writereg,
  output logic                      output_valid,
  input  logic                      output_full
);

  localparam int unsigned NREG = 32'(1) << ADDR_W;

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_reg_t;
  logic [ADDR_W-1:0] w_writereg;

  logic              w_hit_s;
  logic              w_hit_t;
  logic [DATA_W-1:0] w_fwd_s;
  logic [DATA_W-1:0] w_fwd_t;
  logic [DATA_W-1:0] w_operand1;
  logic [DATA_W-1:0] w_operand2;

  logic              w_hazard;
  logic              w_out_stall;
  logic              w_accept;

  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;

  // Raw instruction fields, resized to the register address width
  assign w_op    = input_instruction[31:26];
  assign w_funct = input_instruction[5:0];
  assign w_rs    = ADDR_W'(input_instruction[25:21]);
  assign w_rt    = ADDR_W'(input_instruction[20:16]);
  assign w_rd    = ADDR_W'(input_instruction[15:11]);

  // Destination register and second-source selection by opcode class
  always_comb begin
    w_writereg = '0;
    w_reg_t    = '0;
    if (w_op == 6'h00) begin
      if (w_funct != 6'h08) w_writereg = w_rd;
    end else if (w_op == 6'h03) begin
      w_writereg = ADDR_W'(31);
    end else if (w_op inside {[6'h08:6'h0F], [6'h20:6'h25]}) begin
      w_writereg = w_rt;
    end
    if (w_op inside {6'h00, 6'h04, 6'h05, [6'h28:6'h2B]}) w_reg_t = w_rt;
  end

  assign reg_s = w_rs;
  assign reg_t = w_reg_t;

  // Forward lookup: scan high to low so the lowest-index hit wins
  always_comb begin
    w_hit_s = 1'b0;
    w_hit_t = 1'b0;
    w_fwd_s = '0;
    w_fwd_t = '0;
    for (int i = int'(FWD_N) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_reg[i*ADDR_W +: ADDR_W] == w_rs)) begin
        w_hit_s = 1'b1;
        w_fwd_s = fwd_data[i*DATA_W +: DATA_W];
      end
      if (fwd_valid[i] && (fwd_reg[i*ADDR_W +: ADDR_W] == w_reg_t)) begin
        w_hit_t = 1'b1;
        w_fwd_t = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_operand1 = reg_s_data;
    w_operand2 = reg_t_data;
    if (w_rs == '0)      w_operand1 = '0;
    else if (w_hit_s)    w_operand1 = w_fwd_s;
    if (w_reg_t == '0)   w_operand2 = '0;
    else if (w_hit_t)    w_operand2 = w_fwd_t;
  end

  // A forward hit masks the busy bit; register 0 never stalls
  assign w_hazard = ((w_rs    != '0) && r_busy[w_rs]    && !w_hit_s) ||
                    ((w_reg_t != '0) && r_busy[w_reg_t] && !w_hit_t);

  assign w_out_stall = output_valid && output_full;
  assign w_accept    = input_valid && !w_hazard && !w_out_stall && !flush;
  assign input_full  = reset || flush || w_hazard || w_out_stall;

  // Set on accept beats a same-cycle writeback clear
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_reg] = 1'b0;
    if (w_accept && (w_writereg != '0)) w_busy_nxt[w_writereg] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy             <= '0;
      output_valid       <= 1'b0;
      output_address     <= '0;
      output_instruction <= '0;
      output_operand1    <= '0;
      output_operand2    <= '0;
      output_writereg    <= '0;
    end else if (flush) begin
      r_busy       <= '0;
      output_valid <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_accept) begin
        output_valid       <= 1'b1;
        output_address     <= input_address;
        output_instruction <= input_instruction;
        output_operand1    <= w_operand1;
        output_operand2    <= w_operand2;
        output_writereg    <= w_writereg;
      end else if (output_valid && !output_full) begin
        output_valid <= 1'b0;
      end
    end
  end

endmodule
